// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_ctrl
//  Purpose  : Steps the select lines of a 4:1 mux through the enabled
//             channels, holds each one for DWELL cycles, samples the mux
//             output at the end of each dwell and publishes the swept word
//             with a one-cycle valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] en_mask,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic [3:0] sample,
  output logic       sample_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminal count of the dwell counter: the cycle on which y is captured.
  localparam logic [CW-1:0] c_last_cnt = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    shadow_q, shadow_d;
  logic [3:0]    sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d;
  logic          busy_q, busy_d;

  logic [2:0]    nxt;

  // Lowest enabled channel of a mask (mask assumed non-zero by callers).
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next enabled channel above cur; MSB flags whether one exists.
  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign nxt = next_ch(mask_q, sel_q);

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    mask_d         = mask_q;
    shadow_d       = shadow_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (en_mask != 4'b0000)) begin
          mask_d   = en_mask;
          shadow_d = 4'b0000;
          cnt_d    = '0;
          sel_d    = lowest_ch(en_mask);
          state_d  = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (stop) begin
          // Abort beats any capture or end-of-sweep in the same cycle.
          cnt_d   = '0;
          sel_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == c_last_cnt) begin
          shadow_d[sel_q] = y;
          if (nxt[2]) begin
            sel_d = nxt[1:0];
            cnt_d = '0;
          end else begin
            // shadow_d already carries the bit captured this cycle.
            sample_d       = shadow_d;
            sample_valid_d = 1'b1;
            state_d        = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (!stop && cont) begin
          shadow_d = 4'b0000;
          cnt_d    = '0;
          sel_d    = lowest_ch(mask_q);
          state_d  = ST_SCAN;
        end else begin
          cnt_d   = '0;
          sel_d   = 2'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        sel_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sel_q          <= 2'd0;
      mask_q         <= 4'b0000;
      shadow_q       <= 4'b0000;
      sample_q       <= 4'b0000;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      mask_q         <= mask_d;
      shadow_q       <= shadow_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign s0           = sel_q[1];
  assign s1           = sel_q[0];
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_ctrl
//  Purpose  : Directed bench for mux_scan_ctrl with a strobe scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, cont, y;
  logic [3:0] en_mask;
  logic       s0, s1, sample_valid, busy;
  logic [3:0] sample;
  logic [3:0] abcd;   // mux data inputs: bit0=a, bit1=b, bit2=c, bit3=d

  int ecnt   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] word;
    int         at_edge;
  } exp_t;
  exp_t sb[$];

  mux_scan_ctrl #(.DWELL(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .en_mask(en_mask), .y(y), .s0(s0), .s1(s1), .sample(sample),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // 4:1 mux model feeding y back to the controller.
  assign y = abcd[{s0, s1}];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic push(input logic [3:0] w, input int at);
    exp_t e;
    e.word    = w;
    e.at_edge = at;
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  // Accepting edge is t0; on return we are at the negedge after t0.
  task automatic do_start(input logic [3:0] m, output int t0);
    en_mask = m;
    start   = 1'b1;
    t0      = ecnt + 1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expected word and edge.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got sample=%b at edge %0d, required no strobe", sample, ecnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (sample !== e.word || ecnt != e.at_edge) begin
          errors++;
          $display("FAIL strobe: got sample=%b at edge %0d, required %b at edge %0d",
                   sample, ecnt, e.word, e.at_edge);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [3:0] bseq;
    rst = 1'b1; start = 1'b1; stop = 1'b0; cont = 1'b0;
    en_mask = 4'b1111; abcd = 4'b0000;

    // Reset held two cycles with start asserted.
    repeat (2) @(negedge clk);
    check("rst_sel", {30'd0, s0, s1}, 32'd0);
    check("rst_sample", {28'd0, sample}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Full sweep, only d high.
    abcd = 4'b1000;
    do_start(4'b1111, t0);
    push(4'b1000, t0 + 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_sel_%0d", i), {30'd0, s0, s1}, 32'(i / 4));
      check($sformatf("full_busy_%0d", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("full_done_busy", {31'd0, busy}, 32'd1);
    check("full_done_sel", {30'd0, s0, s1}, 32'd3);
    @(negedge clk);
    check("full_idle_busy", {31'd0, busy}, 32'd0);
    check("full_idle_sel", {30'd0, s0, s1}, 32'd0);

    // Sparse mask: channels a and c only.
    abcd = 4'b0101;
    do_start(4'b0101, t0);
    push(4'b0101, t0 + 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sparse_sel_%0d", i), {30'd0, s0, s1}, (i < 4) ? 32'd0 : 32'd2);
      @(negedge clk);
    end
    check("sparse_done_sel", {30'd0, s0, s1}, 32'd2);
    @(negedge clk);
    check("sparse_idle_busy", {31'd0, busy}, 32'd0);

    // Start with an empty mask is ignored.
    do_start(4'b0000, t0);
    check("empty_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("empty_busy2", {31'd0, busy}, 32'd0);
    check("empty_sel", {30'd0, s0, s1}, 32'd0);

    // Continuous mode on a,b with b toggling between sweeps; c,d high
    // so a leaked mask change would corrupt the word and the timing.
    bseq = 4'b1010;   // b for sweep k is bseq[k]
    abcd = 4'b1100;
    cont = 1'b1;
    do_start(4'b0011, t0);
    en_mask = 4'b1111;
    for (int k = 0; k < 4; k++) push({2'b00, bseq[k], 1'b0}, t0 + 8 + 9 * k);
    for (int k = 0; k < 4; k++) begin
      wait_edge(t0 + 8 + 9 * k);
      if (k < 3) abcd[1] = bseq[k + 1];
      else cont = 1'b0;
    end
    wait_edge(t0 + 36);
    check("cont_end_busy", {31'd0, busy}, 32'd0);

    // Abort mid-sweep.
    abcd = 4'b1111;
    do_start(4'b1111, t0);
    wait_edge(t0 + 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sel", {30'd0, s0, s1}, 32'd0);
    check("abort_sample", {28'd0, sample}, 32'b0010);

    // Abort on the final capture cycle.
    do_start(4'b1111, t0);
    wait_edge(t0 + 15);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_last_busy", {31'd0, busy}, 32'd0);
    check("abort_last_valid", {31'd0, sample_valid}, 32'd0);
    check("abort_last_sample", {28'd0, sample}, 32'b0010);

    // Reset during channel 2, then a clean sweep.
    do_start(4'b1111, t0);
    wait_edge(t0 + 9);
    check("midrst_sel_before", {30'd0, s0, s1}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", {30'd0, s0, s1}, 32'd0);
    check("midrst_sample", {28'd0, sample}, 32'd0);
    check("midrst_valid", {31'd0, sample_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    abcd = 4'b0110;
    do_start(4'b1111, t0);
    push(4'b0110, t0 + 16);
    wait_edge(t0 + 17);
    check("clean_idle_busy", {31'd0, busy}, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
